// File: rtl/key_loader.sv
// Serial key loader: shifts in a key plus an even-parity bit over valid/ready,
// and commits the key to the locked netlist only when the parity check passes.
module key_loader #(
  parameter int                   KEY_WIDTH = 8,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
  parameter int                   MAX_TRIES = 3,
  parameter int                   CNT_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 key_bit,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 loaded,
  output logic                 err,
  output logic                 lockout,
  output logic [CNT_W-1:0]     fail_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for start; no key committed
  // S_SHIFT  | accepting key bits LSB first, then the parity bit
  // S_CHECK  | one cycle: commit on good parity, count a failure otherwise
  // S_LOADED | key committed and driven; only reset exits
  // S_LOCKOUT| MAX_TRIES failures; decoy key held until reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_LOADED,
    S_LOCKOUT
  } state_t;

  localparam int               BC_W        = $clog2(KEY_WIDTH + 1);
  localparam logic [BC_W-1:0]  BITS_INIT   = BC_W'(KEY_WIDTH);
  localparam logic [CNT_W-1:0] TRIES_LIMIT = CNT_W'(MAX_TRIES);

  state_t               state;
  logic [KEY_WIDTH-1:0] shadow;
  logic [BC_W-1:0]      bits_left;
  logic                 parity;
  logic [CNT_W-1:0]     fail_next;

  assign fail_next = fail_cnt + 1'b1;
  assign key_ready = (state == S_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      key_out   <= DECOY_KEY;
      loaded    <= 1'b0;
      err       <= 1'b0;
      lockout   <= 1'b0;
      fail_cnt  <= '0;
      shadow    <= '0;
      bits_left <= '0;
      parity    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SHIFT;
            bits_left <= BITS_INIT;
            shadow    <= '0;
            parity    <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (key_valid) begin
            parity <= parity ^ key_bit;
            // bits_left reaching zero means this transfer is the parity bit
            if (bits_left == '0) begin
              state <= S_CHECK;
            end else begin
              shadow    <= {key_bit, shadow[KEY_WIDTH-1:1]};
              bits_left <= bits_left - 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (!parity) begin
            key_out <= shadow;
            loaded  <= 1'b1;
            state   <= S_LOADED;
          end else begin
            err      <= 1'b1;
            fail_cnt <= fail_next;
            if (fail_next == TRIES_LIMIT) begin
              lockout <= 1'b1;
              state   <= S_LOCKOUT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_LOADED, S_LOCKOUT: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Randomized self-checking bench for key_loader against a session-level model
// of what the locked netlist should see after each load attempt.
module tb_key_loader;

  logic       clk = 1'b0;
  logic       rst, start, key_bit, key_valid;
  logic       key_ready;
  logic [7:0] key_out;
  logic       loaded, err, lockout;
  logic [1:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_key;
  bit         m_loaded, m_lock;
  int         m_fail;

  key_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_bit   (key_bit),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_out   (key_out),
    .loaded    (loaded),
    .err       (err),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input bit exp_err);
    chk({tag, "/key_out"},  32'(key_out),  m_loaded ? 32'(m_key) : 32'h0);
    chk({tag, "/loaded"},   32'(loaded),   32'(m_loaded));
    chk({tag, "/lockout"},  32'(lockout),  32'(m_lock));
    chk({tag, "/fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    chk({tag, "/err"},      32'(err),      32'(exp_err));
  endtask

  task automatic model_reset();
    m_key    = 8'h00;
    m_loaded = 1'b0;
    m_lock   = 1'b0;
    m_fail   = 0;
  endtask

  // Raise rst between edges and look at outputs before any clock edge arrives.
  task automatic pulse_reset();
    @(negedge clk);
    start     = 1'b0;
    key_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_state("rst_async", 1'b0);
    chk("rst_async/key_ready", 32'(key_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic session(input logic [7:0] key, input bit par, input bit alt,
                         input int gap_pct, input bit poke, input int abort_at);
    bit         active;
    bit         pass;
    logic [8:0] bits;
    int         idx;
    int         cyc;
    active = !m_loaded && !m_lock;
    bits   = {par, key};
    idx    = 0;
    cyc    = 0;
    @(negedge clk);
    start     = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (!active) begin
      repeat (12) begin
        chk("ignored/key_ready", 32'(key_ready), 32'h0);
        chk_state("ignored", 1'b0);
        start     = 1'($urandom_range(1));
        key_valid = 1'($urandom_range(1));
        key_bit   = 1'($urandom_range(1));
        @(negedge clk);
      end
      start     = 1'b0;
      key_valid = 1'b0;
      return;
    end
    while (idx < 9) begin
      if (cyc >= 200) begin
        chk("shift_timeout", 32'(idx), 32'd9);
        key_valid = 1'b0;
        start     = 1'b0;
        return;
      end
      if (idx == abort_at) begin
        pulse_reset();
        return;
      end
      chk("shift/key_ready", 32'(key_ready), 32'h1);
      chk_state("shift", 1'b0);
      key_valid = alt ? ((cyc % 2) == 1) : (int'($urandom_range(99)) >= gap_pct);
      key_bit   = key_valid ? bits[idx] : 1'($urandom_range(1));
      start     = poke ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk);
      if (key_valid) idx++;
      cyc++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    start     = 1'b0;
    chk("check/key_ready", 32'(key_ready), 32'h0);
    chk_state("check", 1'b0);
    @(negedge clk);
    pass = ((^bits) == 1'b0);
    if (pass) begin
      m_key    = key;
      m_loaded = 1'b1;
    end else begin
      m_fail++;
      if (m_fail == 3) m_lock = 1'b1;
    end
    chk("commit/key_ready", 32'(key_ready), 32'h0);
    chk_state("commit", !pass);
    @(negedge clk);
    chk_state("after", 1'b0);
  endtask

  initial begin
    logic [7:0] k;
    bit         p;
    rst       = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_state("rst_hold", 1'b0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk_state("idle", 1'b0);
      chk("idle/key_ready", 32'(key_ready), 32'h0);
    end

    session(8'hA5, 1'b0, 1'b0, 0, 1'b0, -1);
    session(8'h3C, 1'b0, 1'b0, 0, 1'b0, -1);

    pulse_reset();
    session(8'hA5, 1'b1, 1'b0, 0, 1'b0, -1);
    session(8'hA5, 1'b0, 1'b0, 0, 1'b0, -1);

    pulse_reset();
    repeat (3) begin
      k = 8'($urandom);
      session(k, ~^k, 1'b0, 20, 1'b0, -1);
    end
    session(8'h11, 1'b0, 1'b0, 0, 1'b0, -1);
    pulse_reset();

    session(8'h3C, 1'b0, 1'b1, 0, 1'b1, -1);

    pulse_reset();
    session(8'h77, 1'b0, 1'b0, 0, 1'b0, 4);
    session(8'h5A, 1'b0, 1'b0, 0, 1'b0, -1);
    pulse_reset();
    session(8'h5A, 1'b0, 1'b0, 0, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) pulse_reset();
      k = 8'($urandom);
      p = ($urandom_range(9) < 6) ? ^k : ~^k;
      session(k, p, 1'b0, int'($urandom_range(40)), 1'($urandom_range(1)),
              ($urandom_range(7) == 0) ? int'($urandom_range(8)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
